alu_rr_scheduler: RTL and testbench

- Shares one combinational 128-bit ALU instance (opcodes 0..8: ADD, SUB, AND, OR, MUL, PASSB, DIV, XNOR, XOR) between NUM_REQ requesters.
- Round-robin arbitration, registered operand issue, one-cycle ALU settle, registered result capture, and a single tagged response channel with valid/ready handshake.
- Sits between requester agents and the ALU; the ALU itself is instantiated outside this block.

---
 rtl/alu_rr_scheduler.sv | 160 ++++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - round-robin scheduler sharing one external ALU between NUM_REQ requesters.
// Optional macro ALU_RR_SCHED_ERR_EN adds rsp_err (opcode > 8 or divide by zero) and zeroes the result on error.
module alu_rr_scheduler #(
  parameter int WIDTH   = 128,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*4-1:0]       req_opcode,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [3:0]                 alu_opcode,
  output logic [WIDTH-1:0]           alu_input1,
  output logic [WIDTH-1:0]           alu_input2,
  input  logic [WIDTH-1:0]           alu_result,
  input  logic [3:0]                 alu_flags,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [WIDTH-1:0]           rsp_result,
  output logic [3:0]                 rsp_flags,
`ifdef ALU_RR_SCHED_ERR_EN
  output logic                       rsp_err,
`endif
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic [ID_W-1:0]   last_grant;
  logic              upper_found;
  logic              lower_found;
  logic [ID_W-1:0]   upper_id;
  logic [ID_W-1:0]   lower_id;
  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic [3:0]        sel_opcode;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic              op_err;

  // Rotating priority: lowest valid index above last_grant wins, else lowest valid overall.
  always_comb begin
    upper_found = 1'b0;
    upper_id    = '0;
    lower_found = 1'b0;
    lower_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (i > int'(last_grant)) begin
          upper_found = 1'b1;
          upper_id    = ID_W'(i);
        end else begin
          lower_found = 1'b1;
          lower_id    = ID_W'(i);
        end
      end
    end
    grant_found = upper_found | lower_found;
    grant_id    = upper_found ? upper_id : lower_id;
  end

  always_comb begin
    sel_opcode = '0;
    sel_a      = '0;
    sel_b      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_opcode = req_opcode[4*i +: 4];
        sel_a      = req_a[WIDTH*i +: WIDTH];
        sel_b      = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

`ifdef ALU_RR_SCHED_ERR_EN
  assign op_err = (alu_opcode > 4'd8) || ((alu_opcode == 4'd6) && (alu_input2 == '0));
`else
  assign op_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // req_ready is gated by rst_n so it stays low while reset is held.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          state_next = EXEC;
          for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = rst_n && (grant_id == ID_W'(i));
          end
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      alu_opcode <= '0;
      alu_input1 <= '0;
      alu_input2 <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
`ifdef ALU_RR_SCHED_ERR_EN
      rsp_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            alu_opcode <= sel_opcode;
            alu_input1 <= sel_a;
            alu_input2 <= sel_b;
            rsp_id     <= grant_id;
          end
        end
        EXEC: begin
          rsp_result <= op_err ? '0 : alu_result;
          rsp_flags  <= alu_flags;
`ifdef ALU_RR_SCHED_ERR_EN
          rsp_err    <= op_err;
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            last_grant <= rsp_id;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb/tb_alu_rr_scheduler.sv - randomized self-checking bench for alu_rr_scheduler with a behavioural ALU and arbiter model.
module tb_alu_rr_scheduler;
  localparam int W   = 128;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*4-1:0]   req_opcode;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [3:0]       alu_opcode;
  logic [W-1:0]     alu_input1;
  logic [W-1:0]     alu_input2;
  logic [W-1:0]     alu_result;
  logic [3:0]       alu_flags;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [W-1:0]     rsp_result;
  logic [3:0]       rsp_flags;
  logic             busy;
`ifdef ALU_RR_SCHED_ERR_EN
  logic             rsp_err;
`endif

  int vectors = 0;
  int errors  = 0;

  bit         r_v  [N];
  logic [3:0] r_op [N];
  logic [W-1:0] r_a [N];
  logic [W-1:0] r_b [N];
  int         m_last;

  always #5 clk = ~clk;

  // Reference ALU: returns {carry, zero, overflow, sign, result}.
  function automatic logic [W+3:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   w;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    c = 1'b0; v = 1'b0; r = '0; w = '0;
    case (op)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[W-1:0]; c = w[W]; v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[W-1:0]; c = w[W]; v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a * b;
      4'd5: r = b;
      4'd6: r = (b == '0) ? '0 : a / b;
      4'd7: r = ~(a ^ b);
      4'd8: r = a ^ b;
      default: r = '0;
    endcase
    return {c, (r == '0), v, r[W-1], r};
  endfunction

  assign {alu_flags, alu_result} = alu_ref(alu_opcode, alu_input1, alu_input2);

  alu_rr_scheduler #(.WIDTH(W), .NUM_REQ(N), .ID_W(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_opcode (alu_opcode),
    .alu_input1 (alu_input1),
    .alu_input2 (alu_input2),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
`ifdef ALU_RR_SCHED_ERR_EN
    .rsp_err    (rsp_err),
`endif
    .busy       (busy)
  );

  function automatic logic [W-1:0] rand_wide();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic bit exp_err(input int g);
    return (r_op[g] > 4'd8) || ((r_op[g] == 4'd6) && (r_b[g] == '0));
  endfunction

  // Expected {flags, result} for requester g; an erroring op returns a zero result when the option is built in.
  function automatic logic [W+3:0] exp_rsp(input int g);
    logic [W+3:0] x;
    x = alu_ref(r_op[g], r_a[g], r_b[g]);
`ifdef ALU_RR_SCHED_ERR_EN
    if (exp_err(g)) x[W-1:0] = '0;
`endif
    return x;
  endfunction

  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      if (r_v[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = r_v[i];
      req_opcode[4*i +: 4]  = r_op[i];
      req_a[W*i +: W]       = r_a[i];
      req_b[W*i +: W]       = r_b[i];
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    r_v[i] = 1'b1; r_op[i] = op; r_a[i] = a; r_b[i] = b;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 4'($urandom_range(0, 11)), rand_wide(),
            ($urandom_range(0, 3) == 0) ? '0 : (rand_wide() >> $urandom_range(0, 127)));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      r_v[i] = 1'b0; r_op[i] = '0; r_a[i] = '0; r_b[i] = '0;
    end
    drive_reqs();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    m_last = N - 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      r_v[i] = 1'b1; r_op[i] = 4'd3; r_a[i] = '1; r_b[i] = '1;
    end
    drive_reqs();
    rsp_ready = 1'b1;
    #3;
    vectors++;
    if (req_ready !== '0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ready=%b busy=%b rsp_valid=%b want 0/0/0", req_ready, busy, rsp_valid);
    end
    do_reset();
    @(posedge clk); #4;
    vectors++;
    if (alu_opcode !== '0 || alu_input1 !== '0 || alu_input2 !== '0 || rsp_id !== '0 ||
        rsp_result !== '0 || rsp_flags !== '0 || busy !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL reset_regs got op=%h a=%h b=%h id=%0d res=%h flags=%b busy=%b want all zero",
               alu_opcode, alu_input1, alu_input2, rsp_id, rsp_result, rsp_flags, busy);
    end
  endtask

  // Single request through to its response with literal expectations.
  task automatic test_one(input string name, input int g, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] want_res, input logic [3:0] want_flags);
    @(posedge clk); #2;
    set_req(g, op, a, b); drive_reqs(); rsp_ready = 1'b1; #2;
    vectors++;
    if (req_ready !== 4'(1 << g)) begin
      errors++; $display("FAIL %s_grant got %b want %b", name, req_ready, 4'(1 << g));
    end
    @(posedge clk); #2;
    r_v[g] = 1'b0; drive_reqs(); #2;
    vectors++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL %s_exec got ready=%b rsp_valid=%b busy=%b want 0000/0/1", name, req_ready, rsp_valid, busy);
    end
    @(posedge clk); #4;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== IDW'(g) || rsp_result !== want_res || rsp_flags !== want_flags) begin
      errors++;
      $display("FAIL %s_rsp got v=%b id=%0d res=%h flags=%b want v=1 id=%0d res=%h flags=%b",
               name, rsp_valid, rsp_id, rsp_result, rsp_flags, g, want_res, want_flags);
    end
    @(posedge clk); #4;
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_done got rsp_valid=%b busy=%b want 0/0", name, rsp_valid, busy);
    end
    m_last = g;
  endtask

  task automatic run_txns(input int n, input bit random_mode);
    for (int t = 0; t < n; t++) begin
      int g;
      int k;
      logic [W+3:0] exp;
      logic [3:0]   eop;
      logic [W-1:0] ea;
      logic [W-1:0] eb;
      bit           eerr;
      @(posedge clk); #2;
      rsp_ready = 1'b0;
      if (random_mode) begin
        for (int i = 0; i < N; i++) begin
          if (!r_v[i] && $urandom_range(0, 1) == 1) rand_req(i);
          else if (r_v[i] && $urandom_range(0, 7) == 0) r_v[i] = 1'b0;
        end
      end
      drive_reqs();
      g = rr_pick();
      #2;
      vectors++;
      if (g < 0) begin
        if (req_ready !== '0 || busy !== 1'b0) begin
          errors++; $display("FAIL idle t=%0d got ready=%b busy=%b want 0000/0", t, req_ready, busy);
        end
        continue;
      end
      if (req_ready !== 4'(1 << g) || busy !== 1'b0) begin
        errors++; $display("FAIL grant t=%0d got ready=%b busy=%b want %b/0", t, req_ready, busy, 4'(1 << g));
      end
      exp = exp_rsp(g); eerr = exp_err(g); eop = r_op[g]; ea = r_a[g]; eb = r_b[g];
      @(posedge clk); #2;
      if (!random_mode || $urandom_range(0, 1) == 1) rand_req(g);
      else r_v[g] = 1'b0;
      drive_reqs(); #2;
      vectors++;
      if (req_ready !== '0 || busy !== 1'b1 || rsp_valid !== 1'b0 ||
          alu_opcode !== eop || alu_input1 !== ea || alu_input2 !== eb) begin
        errors++;
        $display("FAIL issue t=%0d got ready=%b busy=%b v=%b op=%h a=%h b=%h want op=%h a=%h b=%h",
                 t, req_ready, busy, rsp_valid, alu_opcode, alu_input1, alu_input2, eop, ea, eb);
      end
      k = random_mode ? int'($urandom_range(0, 3)) : 0;
      for (int j = 0; j <= k; j++) begin
        @(posedge clk); #2;
        rsp_ready = (j == k); #2;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== IDW'(g) || {rsp_flags, rsp_result} !== exp ||
            req_ready !== '0 || busy !== 1'b1 || alu_opcode !== eop) begin
          errors++;
          $display("FAIL resp t=%0d j=%0d got v=%b id=%0d res=%h flags=%b ready=%b want id=%0d res=%h flags=%b",
                   t, j, rsp_valid, rsp_id, rsp_result, rsp_flags, req_ready, g, exp[W-1:0], exp[W+3:W]);
        end
`ifdef ALU_RR_SCHED_ERR_EN
        vectors++;
        if (rsp_err !== eerr) begin
          errors++; $display("FAIL resp_err t=%0d got %b want %b", t, rsp_err, eerr);
        end
`else
        if (eerr && 0) errors++;
`endif
      end
      m_last = g;
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) rand_req(i);
    run_txns(9, 1'b0);
  endtask

  task automatic test_backpressure();
    int g;
    logic [W+3:0] exp;
    for (int i = 0; i < N; i++) if (!r_v[i]) rand_req(i);
    @(posedge clk); #2;
    rsp_ready = 1'b0; drive_reqs(); g = rr_pick(); #2;
    vectors++;
    if (req_ready !== 4'(1 << g)) begin
      errors++; $display("FAIL bp_grant got %b want %b", req_ready, 4'(1 << g));
    end
    exp = exp_rsp(g);
    @(posedge clk); #2;
    rand_req(g); drive_reqs();
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #2;
      rsp_ready = (j == 5); #2;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(g) || {rsp_flags, rsp_result} !== exp ||
          req_ready !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold j=%0d got v=%b id=%0d res=%h ready=%b busy=%b want id=%0d res=%h",
                 j, rsp_valid, rsp_id, rsp_result, req_ready, busy, g, exp[W-1:0]);
      end
    end
    @(posedge clk); #2;
    rsp_ready = 1'b0; #2;
    vectors++;
    if (req_ready !== 4'(1 << ((g + 1) % N))) begin
      errors++; $display("FAIL bp_next got %b want %b", req_ready, 4'(1 << ((g + 1) % N)));
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) rand_req(i);
    m_last = 1;
    @(posedge clk); #2;
    drive_reqs(); rsp_ready = 1'b1; #2;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || alu_opcode !== '0 || alu_input1 !== '0) begin
      errors++;
      $display("FAIL reset_mid got v=%b busy=%b ready=%b op=%h want all zero", rsp_valid, busy, req_ready, alu_opcode);
    end
    @(posedge clk); #2;
    rst_n = 1'b1; #2;
    vectors++;
    if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_regrant got ready=%b v=%b want 0001/0", req_ready, rsp_valid);
    end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    run_txns(80, 1'b1);
    do_reset();
  endtask

`ifdef ALU_RR_SCHED_ERR_EN
  task automatic test_err();
    logic [W-1:0] bv [2];
    logic [W-1:0] want [2];
    bit           werr [2];
    bv[0] = '0;       want[0] = '0;       werr[0] = 1'b1;
    bv[1] = W'(7);    want[1] = W'(14);   werr[1] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #2;
      set_req(1, 4'd6, W'(100), bv[c]); drive_reqs(); rsp_ready = 1'b1;
      @(posedge clk); #2;
      r_v[1] = 1'b0; drive_reqs();
      @(posedge clk); #4;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_err !== werr[c] || rsp_result !== want[c]) begin
        errors++;
        $display("FAIL err_div c=%0d got v=%b err=%b res=%h want v=1 err=%b res=%h",
                 c, rsp_valid, rsp_err, rsp_result, werr[c], want[c]);
      end
      @(posedge clk); #4;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_one("add", 0, 4'd0, W'(5), W'(7), W'(12), 4'b0000);
    test_one("sub", 2, 4'd1, '0, W'(1), '1, 4'b1001);
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef ALU_RR_SCHED_ERR_EN
    test_err();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
